fpu_wb_stage: RTL and testbench

- Writeback stage downstream of the FPU execution units, including the FCVT.S.W/FCVT.S.WU integer-to-float converter.
- Buffers completed FPU results in a small FIFO and routes each one to either the FP register file or the shared integer register-file write port.
- Accumulates IEEE exception flags into the fcsr fflags field.
- Decouples fixed-latency FPU units from integer write-port contention.

---
 rtl/fpu_wb_stage.sv | 147 ++++++++++++++
 tb/tb_fpu_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_stage.sv
// -----------------------------------------------------------------------------
// fpu_wb_stage
//
// Writeback stage that sits after the FPU execution units. Completed results
// are queued in a small FIFO. Each result is then sent to either the FP
// register file or the shared integer register-file write port. The IEEE
// exception flags of every retired result are OR-ed into fflags. The FIFO
// lets fixed-latency FPU units keep running while the integer write port is
// claimed by the integer pipeline.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   AW    : pointer width, log2(DEPTH)
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   resValid_i / resReady_o   result handshake from the FPU
//   resData_i, resRd_i        result value and destination register
//   resToInt_i                1 = integer regfile destination, 0 = FP regfile
//   resFflags_i               NV,DZ,OF,UF,NX flags of this result
//   flush_i                   synchronous discard of all buffered results
//   intPortBusy_i             integer write port is taken this cycle
//   fpWr*_o                   FP regfile write port
//   intWr*_o                  integer regfile write port
//   csrFflagsWe_i/Data_i      CSR write to fflags
//   fflags_o                  accumulated exception flags
//   fpuIdle_o                 FIFO empty
// -----------------------------------------------------------------------------
module fpu_wb_stage #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resValid_i,
  output logic        resReady_o,
  input  logic [31:0] resData_i,
  input  logic [4:0]  resRd_i,
  input  logic        resToInt_i,
  input  logic [4:0]  resFflags_i,
  input  logic        flush_i,
  input  logic        intPortBusy_i,
  output logic        fpWrEn_o,
  output logic [4:0]  fpWrAddr_o,
  output logic [31:0] fpWrData_o,
  output logic        intWrEn_o,
  output logic [4:0]  intWrAddr_o,
  output logic [31:0] intWrData_o,
  input  logic        csrFflagsWe_i,
  input  logic [4:0]  csrFflagsData_i,
  output logic [4:0]  fflags_o,
  output logic        fpuIdle_o
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        toInt;
    logic [4:0]  fflags;
  } entry_t;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic [AW:0]   countNext;
  entry_t        head;
  logic          empty;
  logic          pushEn;
  logic          popEn;
  logic [4:0]    popFlags;

  assign empty      = (count == '0);
  assign head       = mem[rdPtr];
  assign fpuIdle_o  = empty;

  // Ready depends on count only: a full FIFO never takes a new result in the
  // same cycle it retires the head.
  assign resReady_o = (count != FullCount);

  assign pushEn = resValid_i && resReady_o && !flush_i;

  // A to-int head waits for the shared port even when rd=0. That way it
  // retires in order and its flags are counted.
  assign popEn  = !empty && (!head.toInt || !intPortBusy_i) && !flush_i;

  // Flags are taken only from a result that actually retires. That covers
  // the flush cycle as well.
  assign popFlags = popEn ? head.fflags : 5'd0;

  // Write enables show the head combinationally, also during a flush cycle.
  assign fpWrEn_o    = !empty && !head.toInt;
  assign fpWrAddr_o  = head.rd;
  assign fpWrData_o  = head.data;
  assign intWrEn_o   = !empty && head.toInt && !intPortBusy_i && (head.rd != 5'd0);
  assign intWrAddr_o = head.rd;
  assign intWrData_o = head.data;

  always_comb begin
    // NOTE: assign a default first so every path drives countNext; otherwise a latch is inferred.
    countNext = count;
    if (pushEn && !popEn) begin
      countNext = count + (AW+1)'(1);
    end else if (!pushEn && popEn) begin
      countNext = count - (AW+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + AW'(1);
      if (popEn)  rdPtr <= rdPtr + AW'(1);
      count <= countNext;
    end
  end

  // Flags of a result retiring in the same cycle as a CSR write are OR-ed
  // into the written value, so they are not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fflags_o <= 5'd0;
    end else if (csrFflagsWe_i) begin
      fflags_o <= csrFflagsData_i | popFlags;
    end else begin
      fflags_o <= fflags_o | popFlags;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      mem[wrPtr] <= {resData_i, resRd_i, resToInt_i, resFflags_i};
    end
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
module tb_fpu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        resValid;
  logic        resReady;
  logic [31:0] resData;
  logic [4:0]  resRd;
  logic        resToInt;
  logic [4:0]  resFflags;
  logic        flush;
  logic        intPortBusy;
  logic        fpWrEn;
  logic [4:0]  fpWrAddr;
  logic [31:0] fpWrData;
  logic        intWrEn;
  logic [4:0]  intWrAddr;
  logic [31:0] intWrData;
  logic        csrFflagsWe;
  logic [4:0]  csrFflagsData;
  logic [4:0]  fflags;
  logic        fpuIdle;

  int total = 0;
  int bad   = 0;

  fpu_wb_stage #(.DEPTH(2), .AW(1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .resValid_i     (resValid),
    .resReady_o     (resReady),
    .resData_i      (resData),
    .resRd_i        (resRd),
    .resToInt_i     (resToInt),
    .resFflags_i    (resFflags),
    .flush_i        (flush),
    .intPortBusy_i  (intPortBusy),
    .fpWrEn_o       (fpWrEn),
    .fpWrAddr_o     (fpWrAddr),
    .fpWrData_o     (fpWrData),
    .intWrEn_o      (intWrEn),
    .intWrAddr_o    (intWrAddr),
    .intWrData_o    (intWrData),
    .csrFflagsWe_i  (csrFflagsWe),
    .csrFflagsData_i(csrFflagsData),
    .fflags_o       (fflags),
    .fpuIdle_o      (fpuIdle)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected just before the next edge.
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        toInt;
    logic [4:0]  ff;
    logic        busy;
    logic        flush;
    logic        csrWe;
    logic [4:0]  csrData;
    logic        eReady;
    logic        eFpWe;
    logic        eIntWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    logic        eIdle;
    logic [4:0]  eFflags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, input logic [31:0] data, input logic [4:0] rd,
    input logic toInt, input logic [4:0] ff, input logic busy, input logic fl,
    input logic csrWe, input logic [4:0] csrData,
    input logic eReady, input logic eFpWe, input logic eIntWe,
    input logic [4:0] eAddr, input logic [31:0] eData, input logic eIdle,
    input logic [4:0] eFflags);
    vec_t v;
    v = {valid, data, rd, toInt, ff, busy, fl, csrWe, csrData,
         eReady, eFpWe, eIntWe, eAddr, eData, eIdle, eFflags};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge. Outputs settle 1 time unit later.
  task automatic drive(input logic valid, input logic [31:0] data, input logic [4:0] rd,
                       input logic toInt, input logic [4:0] ff, input logic busy,
                       input logic fl, input logic csrWe, input logic [4:0] csrData);
    @(negedge clk);
    resValid      = valid;
    resData       = data;
    resRd         = rd;
    resToInt      = toInt;
    resFflags     = ff;
    intPortBusy   = busy;
    flush         = fl;
    csrFflagsWe   = csrWe;
    csrFflagsData = csrData;
    #1;
  endtask

  task automatic applyVec(input int i, input vec_t v);
    drive(v.valid, v.data, v.rd, v.toInt, v.ff, v.busy, v.flush, v.csrWe, v.csrData);
    check($sformatf("v%0d.ready", i),  32'(resReady), 32'(v.eReady));
    check($sformatf("v%0d.fpWe", i),   32'(fpWrEn),   32'(v.eFpWe));
    check($sformatf("v%0d.intWe", i),  32'(intWrEn),  32'(v.eIntWe));
    check($sformatf("v%0d.idle", i),   32'(fpuIdle),  32'(v.eIdle));
    check($sformatf("v%0d.fflags", i), 32'(fflags),   32'(v.eFflags));
    if (v.eFpWe) begin
      check($sformatf("v%0d.fpAddr", i), 32'(fpWrAddr), 32'(v.eAddr));
      check($sformatf("v%0d.fpData", i), fpWrData, v.eData);
    end
    if (v.eIntWe) begin
      check($sformatf("v%0d.intAddr", i), 32'(intWrAddr), 32'(v.eAddr));
      check($sformatf("v%0d.intData", i), intWrData, v.eData);
    end
  endtask

  initial begin
    rst = 1'b1;
    resValid = 1'b0; resData = '0; resRd = '0; resToInt = 1'b0; resFflags = '0;
    flush = 1'b0; intPortBusy = 1'b0; csrFflagsWe = 1'b0; csrFflagsData = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready",  32'(resReady), 32'd1);
    check("rst.idle",   32'(fpuIdle),  32'd1);
    check("rst.fpWe",   32'(fpWrEn),   32'd0);
    check("rst.intWe",  32'(intWrEn),  32'd0);
    check("rst.fflags", 32'(fflags),   32'd0);

    // ---------------- table-driven single-cycle flows ----------------
    //                 valid data          rd   toInt ff     busy fl  csrWe csrD    rdy  fpWe intWe addr  edata          idle fflags
    // FP writeback
    vecs.push_back(mk(1'b1,32'h3F800000,5'd3,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd3,32'h3F800000,  1'b0,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));
    // Flag accumulation: NX, then OF|NX
    vecs.push_back(mk(1'b1,32'h11111111,5'd1,1'b0,5'h01,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));
    vecs.push_back(mk(1'b1,32'h22222222,5'd2,1'b0,5'h05,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd1,32'h11111111,  1'b0,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd2,32'h22222222,  1'b0,5'h01));
    // CSR write of 0 in the same cycle as a pop carrying NV
    vecs.push_back(mk(1'b1,32'h33333333,5'd4,1'b0,5'h10,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h05));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b1,5'h00, 1'b1,1'b1,1'b0,5'd4,32'h33333333,  1'b0,5'h05));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h10));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b1,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h10));
    // to-int rd=0: no write pulse, but pops and sets NV
    vecs.push_back(mk(1'b1,32'h0000DEAD,5'd0,1'b1,5'h10,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b0,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h10));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b1,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h10));
    // Five back-to-back pushes, drained every cycle; pointers wrap
    vecs.push_back(mk(1'b1,32'hA0000001,5'd5,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));
    vecs.push_back(mk(1'b1,32'hA0000002,5'd6,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd5,32'hA0000001,  1'b0,5'h00));
    vecs.push_back(mk(1'b1,32'hA0000003,5'd7,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd6,32'hA0000002,  1'b0,5'h00));
    vecs.push_back(mk(1'b1,32'hA0000004,5'd8,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd7,32'hA0000003,  1'b0,5'h00));
    vecs.push_back(mk(1'b1,32'hA0000005,5'd9,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd8,32'hA0000004,  1'b0,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b1,1'b0,5'd9,32'hA0000005,  1'b0,5'h00));
    vecs.push_back(mk(1'b0,32'h0,       5'd0,1'b0,5'h00,1'b0,1'b0,1'b0,5'h00, 1'b1,1'b0,1'b0,5'd0,32'h0,         1'b1,5'h00));

    foreach (vecs[i]) applyVec(i, vecs[i]);

    // ---------------- port contention, FIFO full ----------------
    drive(1'b1, 32'h0000002A, 5'd10, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("cont0.idle", 32'(fpuIdle), 32'd1);
    drive(1'b1, 32'h40000000, 5'd11, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    check("cont1.intWe", 32'(intWrEn), 32'd0);
    check("cont1.fpWe",  32'(fpWrEn),  32'd0);
    check("cont1.ready", 32'(resReady), 32'd1);
    // Full: this offer must be refused.
    drive(1'b1, 32'h00000BAD, 5'd12, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    check("cont2.ready", 32'(resReady), 32'd0);
    check("cont2.intWe", 32'(intWrEn),  32'd0);
    check("cont2.fpWe",  32'(fpWrEn),   32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    check("cont3.ready", 32'(resReady), 32'd0);
    check("cont3.intWe", 32'(intWrEn),  32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("cont4.intWe",   32'(intWrEn),   32'd1);
    check("cont4.intAddr", 32'(intWrAddr), 32'd10);
    check("cont4.intData", intWrData,      32'h0000002A);
    check("cont4.fpWe",    32'(fpWrEn),    32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("cont5.fpWe",   32'(fpWrEn),   32'd1);
    check("cont5.fpAddr", 32'(fpWrAddr), 32'd11);
    check("cont5.fpData", fpWrData,      32'h40000000);
    check("cont5.intWe",  32'(intWrEn),  32'd0);
    check("cont5.ready",  32'(resReady), 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("cont6.idle", 32'(fpuIdle), 32'd1);
    check("cont6.fpWe", 32'(fpWrEn),  32'd0);

    // ---------------- flush with two buffered entries ----------------
    drive(1'b1, 32'h00000055, 5'd13, 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, 5'h00);
    drive(1'b1, 32'h00000066, 5'd14, 1'b0, 5'h04, 1'b1, 1'b0, 1'b0, 5'h00);
    check("fl1.idle", 32'(fpuIdle), 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00);
    check("fl2.ready",   32'(resReady),  32'd0);
    check("fl2.intWe",   32'(intWrEn),   32'd1);
    check("fl2.intAddr", 32'(intWrAddr), 32'd13);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("fl3.idle",   32'(fpuIdle),  32'd1);
    check("fl3.ready",  32'(resReady), 32'd1);
    check("fl3.fpWe",   32'(fpWrEn),   32'd0);
    check("fl3.intWe",  32'(intWrEn),  32'd0);
    check("fl3.fflags", 32'(fflags),   32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("fl4.fpWe",   32'(fpWrEn),   32'd0);
    check("fl4.fflags", 32'(fflags),   32'd0);

    // ---------------- asynchronous reset mid-drain ----------------
    drive(1'b1, 32'h00000077, 5'd15, 1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 5'h1F);
    drive(1'b1, 32'h00000088, 5'd16, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("ar.preReady",  32'(resReady),  32'd0);
    check("ar.preFflags", 32'(fflags),    32'd31);
    check("ar.preIntWe",  32'(intWrEn),   32'd1);
    check("ar.preAddr",   32'(intWrAddr), 32'd15);
    #1 rst = 1'b1;
    #1;
    check("ar.intWe",  32'(intWrEn),  32'd0);
    check("ar.idle",   32'(fpuIdle),  32'd1);
    check("ar.ready",  32'(resReady), 32'd1);
    check("ar.fflags", 32'(fflags),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
    check("ar.postIdle",  32'(fpuIdle), 32'd1);
    check("ar.postIntWe", 32'(intWrEn), 32'd0);
    check("ar.postFpWe",  32'(fpWrEn),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
